// File: rtl/impl_axi_wr_arbiter_if.sv
// impl_axi_wr_arbiter_if: bundles the requester-side and master-side AXI write
// channels of the arbiter.
//   req_aw_*  : per-requester write address (valid/addr in, ready out)
//   req_w_*   : per-requester single write beat (valid/data/strb in, ready out)
//   req_b_*   : per-requester write response (valid out, shared resp out, ready in)
//   m_aw_*    : master AW channel (valid/addr/id out, ready in)
//   m_w_*     : master W channel (valid/data/strb/last out, ready in)
//   m_b_*     : master B channel (valid/resp/id in, ready out)
// Modport master is the arbiter's view; modport slave is the surrounding logic.
interface impl_axi_wr_arbiter_if #(
   parameter int unsigned NUM_REQ        = 2,
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned AXI_DATA_WIDTH = 32,
   parameter int unsigned AXI_ID_WIDTH   = 16
);
   localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

   logic [NUM_REQ-1:0]                req_aw_valid_i;
   logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] req_aw_addr_i;
   logic [NUM_REQ-1:0]                req_aw_ready_o;
   logic [NUM_REQ-1:0]                req_w_valid_i;
   logic [NUM_REQ*AXI_DATA_WIDTH-1:0] req_w_data_i;
   logic [NUM_REQ*STRB_W-1:0]         req_w_strb_i;
   logic [NUM_REQ-1:0]                req_w_ready_o;
   logic [NUM_REQ-1:0]                req_b_valid_o;
   logic [1:0]                        req_b_resp_o;
   logic [NUM_REQ-1:0]                req_b_ready_i;

   logic                              m_aw_valid_o;
   logic [AXI_ADDR_WIDTH-1:0]         m_aw_addr_o;
   logic [AXI_ID_WIDTH-1:0]           m_aw_id_o;
   logic                              m_aw_ready_i;
   logic                              m_w_valid_o;
   logic [AXI_DATA_WIDTH-1:0]         m_w_data_o;
   logic [STRB_W-1:0]                 m_w_strb_o;
   logic                              m_w_last_o;
   logic                              m_w_ready_i;
   logic                              m_b_valid_i;
   logic [1:0]                        m_b_resp_i;
   logic [AXI_ID_WIDTH-1:0]           m_b_id_i;
   logic                              m_b_ready_o;

   modport master (
      input  req_aw_valid_i, req_aw_addr_i, req_w_valid_i, req_w_data_i, req_w_strb_i,
             req_b_ready_i, m_aw_ready_i, m_w_ready_i, m_b_valid_i, m_b_resp_i, m_b_id_i,
      output req_aw_ready_o, req_w_ready_o, req_b_valid_o, req_b_resp_o,
             m_aw_valid_o, m_aw_addr_o, m_aw_id_o, m_w_valid_o, m_w_data_o, m_w_strb_o,
             m_w_last_o, m_b_ready_o
   );

   modport slave (
      output req_aw_valid_i, req_aw_addr_i, req_w_valid_i, req_w_data_i, req_w_strb_i,
             req_b_ready_i, m_aw_ready_i, m_w_ready_i, m_b_valid_i, m_b_resp_i, m_b_id_i,
      input  req_aw_ready_o, req_w_ready_o, req_b_valid_o, req_b_resp_o,
             m_aw_valid_o, m_aw_addr_o, m_aw_id_o, m_w_valid_o, m_w_data_o, m_w_strb_o,
             m_w_last_o, m_b_ready_o
   );
endinterface

// File: rtl/impl_axi_wr_arbiter.sv
// impl_axi_wr_arbiter: round-robin arbiter letting NUM_REQ single-beat write
// requesters share one AXI master port, one transaction in flight at a time.
//   clk_i     : clock
//   rst_ni    : synchronous active-low reset
//   bus       : requester and master AXI write channels (master modport)
//   grant_o   : one-hot owner of the current transaction, zero when idle
//   busy_o    : a transaction is in progress
//   err_cnt_o : saturating count of non-OKAY responses handed to requesters
module impl_axi_wr_arbiter #(
   parameter int unsigned NUM_REQ        = 2,
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned AXI_DATA_WIDTH = 32,
   parameter int unsigned AXI_ID_WIDTH   = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   impl_axi_wr_arbiter_if.master bus,
   output logic [NUM_REQ-1:0]    grant_o,
   output logic                  busy_o,
   output logic [7:0]            err_cnt_o
);
   localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

   typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W, ST_B} state_e;

   state_e                    state_q, state_d;
   logic [IDX_W-1:0]          gnt_idx_q, gnt_idx_d;
   logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
   logic [7:0]                err_cnt_q, err_cnt_d;

   logic [NUM_REQ-1:0]        gnt_oh;
   logic [IDX_W-1:0]          pick_idx;
   logic [IDX_W-1:0]          cand;
   logic                      pick_vld;
   logic [IDX_W-1:0]          rr_next;
   logic [AXI_ADDR_WIDTH-1:0] sel_addr;
   logic [AXI_DATA_WIDTH-1:0] sel_data;
   logic [STRB_W-1:0]         sel_strb;
   logic                      w_sel_valid;
   logic                      b_sel_ready;
   logic [1:0]                b_resp;

   assign gnt_oh      = NUM_REQ'(1) << gnt_idx_q;
   assign w_sel_valid = |(bus.req_w_valid_i & gnt_oh);
   assign b_sel_ready = |(bus.req_b_ready_i & gnt_oh);
   assign rr_next     = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
   // A response carrying someone else's ID is reported as SLVERR to the owner.
   assign b_resp      = (bus.m_b_id_i == AXI_ID_WIDTH'(gnt_idx_q)) ? bus.m_b_resp_i : 2'b10;

   // First requesting index at or after rr_ptr, wrapping.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = IDX_W'((32'(rr_ptr_q) + i) % NUM_REQ);
         if (!pick_vld && bus.req_aw_valid_i[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   // Payload mux for the granted requester.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      sel_strb = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (gnt_oh[k]) begin
            sel_addr = bus.req_aw_addr_i[k*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
            sel_data = bus.req_w_data_i[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
            sel_strb = bus.req_w_strb_i[k*STRB_W +: STRB_W];
         end
      end
   end

   // Next state and channel routing.
   always_comb begin
      state_d            = state_q;
      gnt_idx_d          = gnt_idx_q;
      rr_ptr_d           = rr_ptr_q;
      err_cnt_d          = err_cnt_q;
      bus.req_aw_ready_o = '0;
      bus.req_w_ready_o  = '0;
      bus.req_b_valid_o  = '0;
      bus.req_b_resp_o   = b_resp;
      bus.m_aw_valid_o   = 1'b0;
      bus.m_aw_addr_o    = sel_addr;
      bus.m_aw_id_o      = AXI_ID_WIDTH'(gnt_idx_q);
      bus.m_w_valid_o    = 1'b0;
      bus.m_w_data_o     = sel_data;
      bus.m_w_strb_o     = sel_strb;
      bus.m_w_last_o     = 1'b1;
      bus.m_b_ready_o    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               gnt_idx_d = pick_idx;
               state_d   = ST_AW;
            end
         end
         ST_AW: begin
            bus.m_aw_valid_o   = 1'b1;
            bus.req_aw_ready_o = {NUM_REQ{bus.m_aw_ready_i}} & gnt_oh;
            if (bus.m_aw_ready_i) state_d = ST_W;
         end
         ST_W: begin
            bus.m_w_valid_o   = w_sel_valid;
            bus.req_w_ready_o = {NUM_REQ{bus.m_w_ready_i}} & gnt_oh;
            if (w_sel_valid && bus.m_w_ready_i) state_d = ST_B;
         end
         ST_B: begin
            bus.req_b_valid_o = {NUM_REQ{bus.m_b_valid_i}} & gnt_oh;
            bus.m_b_ready_o   = b_sel_ready;
            if (bus.m_b_valid_i && b_sel_ready) begin
               state_d  = ST_IDLE;
               rr_ptr_d = rr_next;
               if ((b_resp != 2'b00) && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         gnt_idx_q <= '0;
         rr_ptr_q  <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         gnt_idx_q <= gnt_idx_d;
         rr_ptr_q  <= rr_ptr_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign busy_o    = (state_q != ST_IDLE);
   assign grant_o   = (state_q != ST_IDLE) ? gnt_oh : '0;
   assign err_cnt_o = err_cnt_q;
endmodule

// File: tb/tb_impl_axi_wr_arbiter.sv
// tb_impl_axi_wr_arbiter: drives the arbiter as a set of requesters plus a
// master-side slave, predicting grants and responses from round-robin rules.
module tb_impl_axi_wr_arbiter;
   localparam int NR = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int IW = 16;
   localparam int SW = DW / 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NR-1:0] grant;
   logic          busy;
   logic [7:0]    err_cnt;

   int    n_cmp = 0;
   int    n_bad = 0;
   int    rr_m  = 0;
   int    err_m = 0;
   int    viol_cnt;
   string vmsg;

   logic [AW-1:0] addr_m [NR];
   logic [DW-1:0] data_m [NR];
   logic [SW-1:0] strb_m [NR];

   impl_axi_wr_arbiter_if #(.NUM_REQ(NR), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
                            .AXI_ID_WIDTH(IW)) bus ();

   impl_axi_wr_arbiter #(.NUM_REQ(NR), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
                         .AXI_ID_WIDTH(IW)) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .bus      (bus),
      .grant_o  (grant),
      .busy_o   (busy),
      .err_cnt_o(err_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1);
   end

   task automatic clear_inputs();
      bus.req_aw_valid_i = '0;
      bus.req_w_valid_i  = '0;
      bus.req_b_ready_i  = '0;
      bus.m_aw_ready_i   = 1'b0;
      bus.m_w_ready_i    = 1'b0;
      bus.m_b_valid_i    = 1'b0;
      bus.m_b_resp_i     = 2'b00;
      bus.m_b_id_i       = '0;
   endtask

   task automatic load_payload();
      for (int k = 0; k < NR; k++) begin
         bus.req_aw_addr_i[k*AW +: AW] = addr_m[k];
         bus.req_w_data_i[k*DW +: DW]  = data_m[k];
         bus.req_w_strb_i[k*SW +: SW]  = strb_m[k];
      end
   endtask

   task automatic rand_payload();
      for (int k = 0; k < NR; k++) begin
         addr_m[k] = $urandom;
         data_m[k] = $urandom;
         strb_m[k] = SW'($urandom);
      end
   endtask

   task automatic note(input string s);
      viol_cnt++;
      if (vmsg == "") vmsg = s;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rr_m  = 0;
      err_m = 0;
   endtask

   // Round-robin reference: first requesting index at or after the pointer.
   function automatic int pick(input logic [NR-1:0] m);
      for (int i = 0; i < NR; i++) if (m[(rr_m + i) % NR]) return (rr_m + i) % NR;
      return 0;
   endfunction

   // One complete transaction from an IDLE cycle; per-cycle deviations from the
   // expected channel behaviour are tallied in viol_cnt, observations returned.
   task automatic run_txn(input logic [NR-1:0] mask, input int aw_d, input int w_d,
                          input int wr_d, input int b_d, input int br_d,
                          input logic [1:0] resp, input bit id_bad, input bit drop_aw,
                          output int g, output logic [IW-1:0] o_id,
                          output logic [AW-1:0] o_addr, output logic [DW-1:0] o_data,
                          output logic [SW-1:0] o_strb, output logic [1:0] o_resp);
      logic [NR-1:0] oh, rdy, zero;
      logic          vld;
      logic [1:0]    exp_resp;
      int            n;
      viol_cnt = 0;
      vmsg     = "";
      zero     = '0;
      g        = pick(mask);
      oh       = '0;
      oh[g]    = 1'b1;
      o_id = '0; o_addr = '0; o_data = '0; o_strb = '0; o_resp = '0;
      load_payload();
      bus.req_aw_valid_i = mask;
      #1;
      if ({busy, grant, bus.m_aw_valid_o, bus.m_w_valid_o, bus.m_b_ready_o,
           bus.req_aw_ready_o, bus.req_w_ready_o, bus.req_b_valid_o} !== '0)
         note($sformatf("idle outputs not zero busy=%b grant=%b", busy, grant));
      @(posedge clk); #1;
      for (int k = 0; k <= aw_d; k++) begin
         if (drop_aw && k > 0) bus.req_aw_valid_i = '0;
         bus.m_aw_ready_i = (k == aw_d);
         rdy = (k == aw_d) ? oh : '0;
         #1;
         if (k == 0) begin
            o_id   = bus.m_aw_id_o;
            o_addr = bus.m_aw_addr_o;
         end else if (bus.m_aw_id_o !== o_id || bus.m_aw_addr_o !== o_addr)
            note($sformatf("aw payload moved at aw cycle %0d", k));
         if ({bus.m_aw_valid_o, busy, grant, bus.req_aw_ready_o, bus.m_w_valid_o,
              bus.req_w_ready_o, bus.req_b_valid_o, bus.m_b_ready_o} !==
             {1'b1, 1'b1, oh, rdy, 1'b0, zero, zero, 1'b0})
            note($sformatf("aw cycle %0d: awv=%b grant=%b aw_rdy=%b wv=%b", k,
                           bus.m_aw_valid_o, grant, bus.req_aw_ready_o, bus.m_w_valid_o));
         @(posedge clk); #1;
      end
      bus.req_aw_valid_i = drop_aw ? '0 : (mask & ~oh);
      bus.m_aw_ready_i   = 1'b0;
      n = (w_d > wr_d) ? w_d : wr_d;
      for (int k = 0; k <= n; k++) begin
         vld = (k >= w_d);
         rdy = (k >= wr_d) ? oh : '0;
         bus.req_w_valid_i = (vld ? oh : zero) | (NR'($urandom) & ~oh);
         bus.m_w_ready_i   = (k >= wr_d);
         #1;
         if ({bus.m_w_valid_o, bus.m_w_last_o, busy, grant, bus.req_w_ready_o, bus.m_aw_valid_o,
              bus.req_aw_ready_o, bus.req_b_valid_o, bus.m_b_ready_o} !==
             {vld, 1'b1, 1'b1, oh, rdy, 1'b0, zero, zero, 1'b0})
            note($sformatf("w cycle %0d: wv=%b grant=%b w_rdy=%b awv=%b", k,
                           bus.m_w_valid_o, grant, bus.req_w_ready_o, bus.m_aw_valid_o));
         if (k == n) begin
            o_data = bus.m_w_data_o;
            o_strb = bus.m_w_strb_o;
         end
         @(posedge clk); #1;
      end
      bus.req_w_valid_i = '0;
      bus.m_w_ready_i   = 1'b0;
      bus.m_b_resp_i    = resp;
      bus.m_b_id_i      = id_bad ? IW'(g) + IW'(1) : IW'(g);
      n = (b_d > br_d) ? b_d : br_d;
      for (int k = 0; k <= n; k++) begin
         rdy = (k >= b_d) ? oh : '0;
         vld = (k >= br_d);
         bus.m_b_valid_i   = (k >= b_d);
         bus.req_b_ready_i = (vld ? oh : zero) | (NR'($urandom) & ~oh);
         #1;
         if ({bus.req_b_valid_o, bus.m_b_ready_o, busy, grant, bus.m_aw_valid_o, bus.m_w_valid_o,
              bus.req_aw_ready_o, bus.req_w_ready_o} !==
             {rdy, vld, 1'b1, oh, 1'b0, 1'b0, zero, zero})
            note($sformatf("b cycle %0d: bv=%b brdy=%b grant=%b", k,
                           bus.req_b_valid_o, bus.m_b_ready_o, grant));
         if (k == n) o_resp = bus.req_b_resp_o;
         @(posedge clk); #1;
      end
      clear_inputs();
      #1;
      if ({busy, grant, bus.m_aw_valid_o, bus.m_w_valid_o, bus.m_b_ready_o,
           bus.req_aw_ready_o, bus.req_w_ready_o, bus.req_b_valid_o} !== '0)
         note($sformatf("not idle after response busy=%b grant=%b", busy, grant));
      exp_resp = id_bad ? 2'b10 : resp;
      if (exp_resp != 2'b00 && err_m < 255) err_m++;
      rr_m = (g + 1) % NR;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.req_aw_valid_i = '1; bus.m_aw_ready_i = 1'b1; bus.m_w_ready_i = 1'b1;
      bus.m_b_valid_i = 1'b1; bus.req_b_ready_i = '1; bus.req_w_valid_i = '1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({busy, grant, bus.m_aw_valid_o, bus.m_w_valid_o, bus.m_b_ready_o, bus.req_aw_ready_o,
           bus.req_w_ready_o, bus.req_b_valid_o} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: busy=%b grant=%b awv=%b wv=%b bv=%b, required all 0",
                  busy, grant, bus.m_aw_valid_o, bus.m_w_valid_o, bus.req_b_valid_o);
      end
      n_cmp++;
      if (err_cnt !== 8'd0) begin
         n_bad++;
         $display("FAIL reset_err_cnt: got %0d, required 0", err_cnt);
      end
      do_reset();
   endtask

   task automatic test_single();
      int g; logic [IW-1:0] id; logic [AW-1:0] a; logic [DW-1:0] d; logic [SW-1:0] s;
      logic [1:0] r;
      do_reset();
      rand_payload();
      addr_m[0] = 32'h0000_1000; data_m[0] = 32'hDEAD_BEEF; strb_m[0] = 4'hF;
      run_txn(3'b001, 0, 0, 0, 0, 0, 2'b00, 1'b0, 1'b0, g, id, a, d, s, r);
      n_cmp++;
      if (viol_cnt !== 0) begin
         n_bad++;
         $display("FAIL single_timing: %0d deviations, first: %s; required 0", viol_cnt, vmsg);
      end
      n_cmp++;
      if ({id, a, d, s, r} !== {16'd0, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 2'b00}) begin
         n_bad++;
         $display("FAIL single_payload: id=%h addr=%h data=%h strb=%h resp=%b, required 0/1000/deadbeef/f/00",
                  id, a, d, s, r);
      end
      n_cmp++;
      if (err_cnt !== 8'd0) begin
         n_bad++;
         $display("FAIL single_err_cnt: got %0d, required 0", err_cnt);
      end
   endtask

   task automatic test_round_robin();
      int g; logic [IW-1:0] id; logic [AW-1:0] a; logic [DW-1:0] d; logic [SW-1:0] s;
      logic [1:0] r;
      int order [4] = '{0, 1, 0, 1};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         rand_payload();
         run_txn(3'b011, 0, 0, 0, 0, 0, 2'b00, 1'b0, 1'b0, g, id, a, d, s, r);
         n_cmp++;
         if (id !== IW'(order[i]) || viol_cnt !== 0) begin
            n_bad++;
            $display("FAIL rr_order[%0d]: id=%0d deviations=%0d (%s), required id %0d and 0",
                     i, id, viol_cnt, vmsg, order[i]);
         end
         n_cmp++;
         if (a !== addr_m[order[i]] || d !== data_m[order[i]]) begin
            n_bad++;
            $display("FAIL rr_payload[%0d]: addr=%h data=%h, required %h %h", i, a, d,
                     addr_m[order[i]], data_m[order[i]]);
         end
      end
   endtask

   task automatic test_aw_stall();
      int g; logic [IW-1:0] id; logic [AW-1:0] a; logic [DW-1:0] d; logic [SW-1:0] s;
      logic [1:0] r;
      rand_payload();
      run_txn(3'b100, 5, 0, 0, 0, 0, 2'b00, 1'b0, 1'b1, g, id, a, d, s, r);
      n_cmp++;
      if (viol_cnt !== 0) begin
         n_bad++;
         $display("FAIL aw_stall: %0d deviations, first: %s; required 0", viol_cnt, vmsg);
      end
      n_cmp++;
      if (id !== IW'(g) || a !== addr_m[g]) begin
         n_bad++;
         $display("FAIL aw_stall_payload: id=%0d addr=%h, required %0d %h", id, a, g, addr_m[g]);
      end
   endtask

   task automatic test_id_mismatch();
      int g; logic [IW-1:0] id; logic [AW-1:0] a; logic [DW-1:0] d; logic [SW-1:0] s;
      logic [1:0] r;
      do_reset();
      rand_payload();
      run_txn(3'b001, 0, 1, 0, 1, 0, 2'b00, 1'b1, 1'b0, g, id, a, d, s, r);
      n_cmp++;
      if (r !== 2'b10 || viol_cnt !== 0) begin
         n_bad++;
         $display("FAIL id_mismatch_resp: resp=%b deviations=%0d (%s), required 10 and 0",
                  r, viol_cnt, vmsg);
      end
      n_cmp++;
      if (err_cnt !== 8'd1) begin
         n_bad++;
         $display("FAIL id_mismatch_err_cnt: got %0d, required 1", err_cnt);
      end
      run_txn(3'b001, 0, 0, 0, 0, 0, 2'b00, 1'b0, 1'b0, g, id, a, d, s, r);
      n_cmp++;
      if (r !== 2'b00 || err_cnt !== 8'd1) begin
         n_bad++;
         $display("FAIL id_match_okay: resp=%b err_cnt=%0d, required 00 and 1", r, err_cnt);
      end
   endtask

   task automatic test_err_saturation();
      int g; logic [IW-1:0] id; logic [AW-1:0] a; logic [DW-1:0] d; logic [SW-1:0] s;
      logic [1:0] r;
      int dev = 0;
      for (int i = 0; i < 300; i++) begin
         run_txn(NR'($urandom_range(1, (1 << NR) - 1)), 0, 0, 0, 0, 0, 2'b10, 1'b0, 1'b0,
                 g, id, a, d, s, r);
         dev += viol_cnt;
         n_cmp++;
         if (err_cnt !== 8'(err_m)) begin
            n_bad++;
            $display("FAIL err_sat[%0d]: err_cnt=%0d, required %0d", i, err_cnt, err_m);
         end
      end
      n_cmp++;
      if (err_cnt !== 8'd255 || dev !== 0) begin
         n_bad++;
         $display("FAIL err_sat_final: err_cnt=%0d deviations=%0d, required 255 and 0", err_cnt, dev);
      end
   endtask

   task automatic test_reset_mid();
      int g; logic [IW-1:0] id; logic [AW-1:0] a; logic [DW-1:0] d; logic [SW-1:0] s;
      logic [1:0] r;
      do_reset();
      rand_payload();
      load_payload();
      bus.req_aw_valid_i = 3'b110;
      bus.m_aw_ready_i   = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.req_aw_valid_i = '0;
      bus.m_aw_ready_i   = 1'b0;
      bus.req_w_valid_i  = '1;
      #1;
      n_cmp++;
      if (bus.m_w_valid_o !== 1'b1 || grant !== 3'b010) begin
         n_bad++;
         $display("FAIL midrst_in_w: wv=%b grant=%b, required 1 and 010", bus.m_w_valid_o, grant);
      end
      rst_n = 1'b0;
      bus.m_w_ready_i = 1'b1; bus.m_b_valid_i = 1'b1; bus.req_b_ready_i = '1;
      bus.m_aw_ready_i = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({busy, grant, bus.m_aw_valid_o, bus.m_w_valid_o, bus.m_b_ready_o, bus.req_aw_ready_o,
           bus.req_w_ready_o, bus.req_b_valid_o, err_cnt} !== '0) begin
         n_bad++;
         $display("FAIL midrst_outputs: busy=%b grant=%b wv=%b w_rdy=%b bv=%b err=%0d, required all 0",
                  busy, grant, bus.m_w_valid_o, bus.req_w_ready_o, bus.req_b_valid_o, err_cnt);
      end
      clear_inputs();
      rst_n = 1'b1;
      rr_m  = 0;
      err_m = 0;
      run_txn(3'b111, 0, 0, 0, 0, 0, 2'b00, 1'b0, 1'b0, g, id, a, d, s, r);
      n_cmp++;
      if (id !== 16'd0 || viol_cnt !== 0 || a !== addr_m[0]) begin
         n_bad++;
         $display("FAIL midrst_regrant: id=%0d addr=%h deviations=%0d (%s), required 0 %h 0",
                  id, a, viol_cnt, vmsg, addr_m[0]);
      end
   endtask

   task automatic test_random();
      int g; logic [IW-1:0] id; logic [AW-1:0] a; logic [DW-1:0] d; logic [SW-1:0] s;
      logic [1:0] r, resp, er;
      bit bad_id;
      do_reset();
      for (int i = 0; i < 60; i++) begin
         rand_payload();
         resp   = 2'($urandom);
         bad_id = ($urandom_range(0, 3) == 0);
         er     = bad_id ? 2'b10 : resp;
         run_txn(NR'($urandom_range(1, (1 << NR) - 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), resp, bad_id,
                 1'($urandom_range(0, 1)), g, id, a, d, s, r);
         n_cmp++;
         if (viol_cnt !== 0) begin
            n_bad++;
            $display("FAIL rand[%0d]_cycles: %0d deviations, first: %s; required 0", i, viol_cnt, vmsg);
         end
         n_cmp++;
         if ({id, a, d, s} !== {IW'(g), addr_m[g], data_m[g], strb_m[g]}) begin
            n_bad++;
            $display("FAIL rand[%0d]_payload: id=%0d addr=%h data=%h strb=%h, required %0d %h %h %h",
                     i, id, a, d, s, g, addr_m[g], data_m[g], strb_m[g]);
         end
         n_cmp++;
         if (r !== er || err_cnt !== 8'(err_m)) begin
            n_bad++;
            $display("FAIL rand[%0d]_resp: resp=%b err_cnt=%0d, required %b %0d", i, r, err_cnt, er, err_m);
         end
      end
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      rand_payload();
      load_payload();
      test_reset();
      test_single();
      test_round_robin();
      test_aw_stall();
      test_id_mismatch();
      test_err_saturation();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/impl_axi_wr_arbiter.md
IMPL_AXI_WR_ARBITER -- requirements
Module: impl_axi_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of write requesters sharing one AXI master port; legal range 1..16.
REQ-002 Parameter AXI_ADDR_WIDTH, default 32: address width.
REQ-003 Parameter AXI_DATA_WIDTH, default 32: data width; strobe width is AXI_DATA_WIDTH/8.
REQ-004 Parameter AXI_ID_WIDTH, default 16: master-side ID width; must be at least clog2(NUM_REQ).
REQ-005 The block has one clock; reset is synchronous and active-low.
REQ-006 clk_i  in  1  clock; all state updates on rising edge.
REQ-007 rst_ni  in  1  synchronous active-low reset.
REQ-008 req_aw_valid_i  in  NUM_REQ  per-requester write-address valid.
REQ-009 req_aw_addr_i  in  NUM_REQ*AXI_ADDR_WIDTH  per-requester address, requester k at slice k.
REQ-010 req_aw_ready_o  out  NUM_REQ  per-requester address accept.
REQ-011 req_w_valid_i / req_w_data_i / req_w_strb_i  in  NUM_REQ / NUM_REQ*DATA / NUM_REQ*DATA/8  per-requester single write beat.
REQ-012 req_w_ready_o  out  NUM_REQ  per-requester data accept.
REQ-013 req_b_valid_o  out  NUM_REQ; req_b_resp_o  out  2 (shared); req_b_ready_i  in  NUM_REQ: write response to requester.
REQ-014 m_aw_valid_o, m_aw_addr_o, m_aw_id_o  out  1/ADDR/ID; m_aw_ready_i  in  1: master AW channel.
REQ-015 m_w_valid_o, m_w_data_o, m_w_strb_o, m_w_last_o  out  1/DATA/DATA/8/1; m_w_ready_i  in  1: master W channel.
REQ-016 m_b_valid_i, m_b_resp_i, m_b_id_i  in  1/2/ID; m_b_ready_o  out  1: master B channel.
REQ-017 grant_o  out  NUM_REQ  one-hot current owner, zero in IDLE; busy_o  out  1  high when not IDLE.
REQ-018 err_cnt_o  out  8  saturating count of non-OKAY responses delivered to requesters.

Function
REQ-019 FSM states IDLE, AW, W, B; one transaction (single beat, m_w_last_o=1) outstanding at a time.
REQ-020 IDLE: if any req_aw_valid_i set, select first set index at or after rr_ptr (wrapping modulo NUM_REQ), register it as gnt_idx, go AW next cycle; otherwise stay.
REQ-021 AW: m_aw_valid_o=1, m_aw_addr_o=slice gnt_idx, m_aw_id_o=gnt_idx zero-extended; req_aw_ready_o[gnt_idx]=m_aw_ready_i; on m_aw_ready_i go W.
REQ-022 W: m_w_valid_o=req_w_valid_i[gnt_idx], data/strb from slice gnt_idx, req_w_ready_o[gnt_idx]=m_w_ready_i; on both high go B.
REQ-023 B: req_b_valid_o[gnt_idx]=m_b_valid_i, m_b_ready_o=req_b_ready_i[gnt_idx]; on both high go IDLE, rr_ptr <= (gnt_idx+1) mod NUM_REQ, err_cnt_o increments (saturate at 255) if delivered resp != 2'b00.
REQ-024 req_b_resp_o = m_b_resp_i, except forced 2'b10 (SLVERR) when m_b_id_i != gnt_idx.
REQ-025 All ready/valid outputs to non-granted requesters are 0 in every state; all master valids/ready are 0 in IDLE and outside their own state.
REQ-026 Master valids, once asserted, stay asserted until handshake; no abort if requester drops its valid in AW.
REQ-027 Minimum transaction: 4 cycles (IDLE grant, AW, W, B with immediate readies); next grant evaluated in the IDLE cycle after B.
REQ-028 NUM_REQ=1: rr_ptr constant 0, behaviour otherwise identical.

Reset
REQ-029 While rst_ni=0 at a rising edge: state IDLE, gnt_idx=0, rr_ptr=0, err_cnt_o=0; all valid/ready outputs, grant_o, busy_o = 0.
REQ-030 Reset mid-transaction abandons the transaction; no response is delivered to the requester.

Verification
REQ-031 Single req0 write addr 0x1000 data 0xDEADBEEF, all readies high -> m_aw at cycle 1, m_w cycle 2, req_b_valid_o[0] cycle 3, resp 00, busy_o low cycle 4.
REQ-032 req0 and req1 both always requesting, 4 transactions -> grant order 0,1,0,1; m_aw_id_o matches.
REQ-033 m_aw_ready_i held low 5 cycles in AW -> m_aw_valid_o and address stable throughout, req_aw_ready_o stays 0.
REQ-034 m_b_id_i=1 while gnt_idx=0, m_b_resp_i=00 -> req_b_resp_o=10, err_cnt_o increments to 1.
REQ-035 300 SLVERR responses -> err_cnt_o saturates at 255.
REQ-036 rst_ni low during W state -> next cycle all outputs 0, state IDLE; new request then granted normally starting from requester 0.
